intt_inverse: RTL
=================

Name: intt_inverse

Overview:
- Inverse NTT top level, the counterpart of the forward transform.
- Converts a bit-reversed-order NTT-domain vector of N coefficients back to natural-order coefficients.
- Algorithm: in-place radix-2 Cooley-Tukey DIT with inverse twiddles, followed by a scaling pass by N^-1 mod Q.
- Contains its own dual-port coefficient RAM, inverse twiddle table, butterfly datapath and control FSM.
- Uses the same load / start / done / read usage model as the forward transform, so a round trip is load → forward → read-out → load → inverse.

Parameters:
- N, 256, transform size; power of two, ≥4.
- WIDTH, 32, coefficient width.
- Q, 8380417, prime modulus.
- ADDR_WIDTH, 8, log2(N).
- OMEGA, 3073009, primitive N-th root of unity mod Q.
- N_INV, 8347681, N^-1 mod Q.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  start pulse; honoured only in IDLE
- done  out  1  one-cycle completion pulse
- busy  out  1  high while transform in progress
- load_coeff  in  1  write enable for load interface; ignored while busy
- load_addr  in  ADDR_WIDTH  load address
- load_data  in  WIDTH  load data; must be < Q
- read_addr  in  ADDR_WIDTH  result read address
- read_data  out  WIDTH  RAM[read_addr], 1-cycle registered latency

Behaviour:
- Reset values:
  - Outputs: busy=0, done=0, read_data=0.
  - FSM goes to IDLE; all counters cleared.
  - RAM contents are not cleared.
- Twiddle table:
  - N/2 entries, entry k = OMEGA^(N-k) mod Q.
  - Built at elaboration by a constant function; no runtime generation.
- Loop order:
  - Stage s = 0..log2N-1, with half-size m = 2^s.
  - Twiddle index j = 0..m-1; twiddle = table[j*(N/(2m))].
  - Group base g = 0, 2m, ..., N-2m.
  - Pair addresses: a = g+j, b = g+j+m.
- Butterfly (combinational):
  - t = (w*b) mod Q, using a 2*WIDTH product.
  - a' = (a+t) mod Q.
  - b' = (a-t+Q) mod Q.
  - Outputs are always < Q.
- FSM states: IDLE, RD, WAIT, CALC, WR, S_RD, S_WAIT, S_WR, DONE.
  - IDLE: start=1 → RD; busy goes high the next cycle.
  - RD: drive port A = a, port B = b → WAIT.
  - WAIT: RAM read latency → CALC.
  - CALC: register butterfly outputs → WR.
  - WR: write a' on port A and b' on port B in the same cycle; advance counters; → RD, or → S_RD after the final butterfly of the last stage.
  - Scaling pass: index p = 0..N/2-1; port A = 2p, port B = 2p+1.
    - S_RD → S_WAIT → S_WR.
    - S_WR writes x*N_INV mod Q on both ports.
    - After p = N/2-1 → DONE.
  - DONE: done=1, busy=0 for exactly one cycle → IDLE.
- Timing:
  - busy is high for exactly 4*(N/2)*log2N + 3*(N/2) cycles: 4480 for N=256.
  - done follows on the next cycle.
- Port mux:
  - While busy, the FSM owns both ports; load_coeff and read_addr are ignored, and read_data holds an unspecified value.
  - While idle, port B serves the host, with load_coeff taking priority over read.
  - A read issued in the cycle after a load to the same address returns the new data.
- start while busy or in DONE: ignored; no restart, no queueing.
- start asserted in the same cycle as load_coeff in IDLE: the load is performed and the transform starts. The loaded value is visible to the transform because the first RD occurs a cycle later.
- rst_n asserted mid-transform: immediate return to IDLE with busy=0 and no done pulse. RAM holds partial results; the host must reload.
- Arithmetic: all intermediates are reduced mod Q before write-back. There is no Montgomery domain; plain residues go in and come out.

Test Plan:
- Impulse: X[0]=1, all others 0; start → done after 4480 busy cycles; every read_data[i] = 8347681 (N^-1).
- Constant: X[i]=5 for all i → x[0]=5, x[1..255]=0.
- Round trip: a random vector (<Q) through the golden forward NTT (bit-reversed output) then through this block → the original vector, bit-exact, for 20 seeds.
- Busy behaviour:
  - start pulsed again at cycle 100 → single done pulse at the nominal cycle.
  - load_coeff at cycle 200 with addr 0 and data 7 → no effect on the results.
  - busy=1 throughout; done never overlaps busy.
- Reset mid-operation: rst_n low at cycle 1000 → busy=0 and done=0 immediately. Reload and restart → correct impulse result.
- Boundary values: all inputs Q-1 → x[0]=Q-1, all others 0. No output ≥ Q anywhere; a bench assertion checks every RAM write is < Q.

Source files
------------

// File: rtl/intt_inverse.sv
// Inverse NTT: in-place radix-2 DIT over a bit-reversed spectrum using inverse twiddles,
// followed by a scaling pass by N^-1; the natural-order result is left in the internal RAM.
module intt_inverse #(
  parameter int unsigned N          = 256,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned Q          = 8380417,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned OMEGA      = 3073009,
  parameter int unsigned N_INV      = 8347681
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  done,
  output logic                  busy,
  input  logic                  load_coeff,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [WIDTH-1:0]      load_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [WIDTH-1:0]      read_data
);

  localparam int unsigned W1     = WIDTH + 1;
  localparam int unsigned W2     = 2 * WIDTH;
  localparam int unsigned HALF_W = ADDR_WIDTH - 1;
  localparam int unsigned SW     = $clog2(ADDR_WIDTH);

  localparam logic [W2-1:0]         Q_2W    = W2'(Q);
  localparam logic [W1-1:0]         Q_1W    = W1'(Q);
  localparam logic [WIDTH-1:0]      N_INV_W = WIDTH'(N_INV);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
  localparam logic [HALF_W-1:0]     ONE_P   = HALF_W'(1);
  localparam logic [SW-1:0]         ONE_S   = SW'(1);
  localparam logic [SW-1:0]         LAST_S  = SW'(ADDR_WIDTH - 1);

  function automatic logic [63:0] pow_mod(input logic [63:0] base, input int unsigned e);
    logic [63:0] r;
    logic [63:0] b;
    int unsigned x;
    r = 64'd1;
    b = base % 64'(Q);
    x = e;
    for (int i = 0; i < 32; i++) begin
      if (x[0]) r = (r * b) % 64'(Q);
      b = (b * b) % 64'(Q);
      x = x >> 1;
    end
    return r;
  endfunction

  // Inverse twiddles: entry k = OMEGA^(N-k) = OMEGA^-k, fixed at elaboration.
  logic [WIDTH-1:0] tw_rom [N/2];
  for (genvar k = 0; k < N/2; k++) begin : g_tw
    localparam logic [WIDTH-1:0] TW_K = WIDTH'(pow_mod(64'(OMEGA), N - k));
    assign tw_rom[k] = TW_K;
  end

  // state  | meaning
  // IDLE   | host owns RAM port B; waits for start
  // RD/WAIT/CALC/WR | butterfly: issue read, RAM latency, register a'/b', write both
  // S_RD/S_WAIT/S_WR | scaling pass over pairs (2p, 2p+1)
  // DONE   | one-cycle completion pulse
  typedef enum logic [3:0] {IDLE, RD, WAIT, CALC, WR, S_RD, S_WAIT, S_WR, DONE} state_t;

  state_t                  state;
  logic [SW-1:0]           s;
  logic [ADDR_WIDTH-1:0]   j, g, m;
  logic [HALF_W-1:0]       p, tw_idx;
  logic [2*ADDR_WIDTH-1:0] tw_wide;
  logic [ADDR_WIDTH:0]     g_next;
  logic [ADDR_WIDTH-1:0]   a_addr, b_addr;
  logic                    last_g, last_j, last_s, last_p;

  logic [WIDTH-1:0]      mem [N];
  logic [WIDTH-1:0]      q_a, q_b, bf_a, bf_b, bf_a_n, bf_b_n;
  logic [WIDTH-1:0]      tw, w_b, t_a, t_b;
  logic [W1-1:0]         sum, dif;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b;
  logic [WIDTH-1:0]      wdata_a, wdata_b;
  logic                  we_a, we_b, scale_sel;

  assign m       = ONE_A << s;
  assign tw_wide = ({j, {ADDR_WIDTH{1'b0}}} >> s) >> 1;
  assign tw_idx  = HALF_W'(tw_wide);
  assign a_addr  = g + j;
  assign b_addr  = g + j + m;
  assign g_next  = {1'b0, g} + {m, 1'b0};
  assign last_g  = g_next[ADDR_WIDTH];
  assign last_j  = (j == m - ONE_A);
  assign last_s  = (s == LAST_S);
  assign last_p  = &p;

  assign scale_sel = (state == S_WR);
  assign tw        = tw_rom[tw_idx];
  assign w_b       = scale_sel ? N_INV_W : tw;
  assign t_b       = WIDTH'(({{WIDTH{1'b0}}, w_b} * {{WIDTH{1'b0}}, q_b}) % Q_2W);
  assign t_a       = WIDTH'(({{WIDTH{1'b0}}, N_INV_W} * {{WIDTH{1'b0}}, q_a}) % Q_2W);
  assign sum       = {1'b0, q_a} + {1'b0, t_b};
  assign dif       = {1'b0, q_a} + Q_1W - {1'b0, t_b};
  assign bf_a_n    = (sum >= Q_1W) ? WIDTH'(sum - Q_1W) : WIDTH'(sum);
  assign bf_b_n    = (dif >= Q_1W) ? WIDTH'(dif - Q_1W) : WIDTH'(dif);

  always_comb begin
    addr_a  = '0;
    addr_b  = '0;
    we_a    = 1'b0;
    we_b    = 1'b0;
    wdata_a = bf_a;
    wdata_b = bf_b;
    case (state)
      RD, WAIT, CALC, WR: begin
        addr_a = a_addr;
        addr_b = b_addr;
        we_a   = (state == WR);
        we_b   = (state == WR);
      end
      S_RD, S_WAIT, S_WR: begin
        addr_a  = {p, 1'b0};
        addr_b  = {p, 1'b1};
        we_a    = scale_sel;
        we_b    = scale_sel;
        wdata_a = t_a;
        wdata_b = t_b;
      end
      default: begin
        addr_b  = load_coeff ? load_addr : read_addr;
        we_b    = load_coeff;
        wdata_b = load_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
    if (we_b) mem[addr_b] <= wdata_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      q_a <= mem[addr_a];
      q_b <= mem[addr_b];
    end
  end

  assign read_data = q_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      j     <= '0;
      g     <= '0;
      p     <= '0;
      bf_a  <= '0;
      bf_b  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RD;
            busy  <= 1'b1;
            s     <= '0;
            j     <= '0;
            g     <= '0;
            p     <= '0;
          end
        end
        RD:   state <= WAIT;
        WAIT: state <= CALC;
        CALC: begin
          bf_a  <= bf_a_n;
          bf_b  <= bf_b_n;
          state <= WR;
        end
        WR: begin
          state <= RD;
          if (!last_g) begin
            g <= g_next[ADDR_WIDTH-1:0];
          end else begin
            g <= '0;
            if (!last_j) begin
              j <= j + ONE_A;
            end else begin
              j <= '0;
              if (!last_s) begin
                s <= s + ONE_S;
              end else begin
                s     <= '0;
                state <= S_RD;
              end
            end
          end
        end
        S_RD:   state <= S_WAIT;
        S_WAIT: state <= S_WR;
        S_WR: begin
          if (last_p) begin
            p     <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            p     <= p + ONE_P;
            state <= S_RD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
